// File: rtl/trail_stack_if.sv
// trail_stack_if: command, pop-output and status bundle for trail_stack.
//   master: drives cmd_valid/cmd_op/cmd_var/cmd_val/cmd_level, observes everything else
//   slave : trail_stack side of the same signals
interface trail_stack_if #(
   parameter int DEPTH = 512,
   parameter int VAR_W = 9,
   parameter int LVL_W = 9
);
   localparam int CW = $clog2(DEPTH + 1);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [VAR_W-1:0] cmd_var;
   logic             cmd_val;
   logic [LVL_W-1:0] cmd_level;
   logic             out_valid;
   logic [VAR_W-1:0] out_var;
   logic             out_val;
   logic             out_is_decision;
   logic             busy;
   logic [CW-1:0]    count;
   logic [LVL_W-1:0] cur_level;
   logic             empty;
   logic             full;
   logic             err_overflow;
   logic             err_underflow;
   modport master (
      output cmd_valid, cmd_op, cmd_var, cmd_val, cmd_level,
      input  cmd_ready, out_valid, out_var, out_val, out_is_decision,
             busy, count, cur_level, empty, full, err_overflow, err_underflow
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_var, cmd_val, cmd_level,
      output cmd_ready, out_valid, out_var, out_val, out_is_decision,
             busy, count, cur_level, empty, full, err_overflow, err_underflow
   );
endinterface

// File: rtl/trail_stack.sv
// trail_stack: SAT assignment trail with decision levels, pop and multi-cycle backtrack.
//   clk_i   : rising-edge clock
//   reset_i : asynchronous active-high reset
//   bus     : trail_stack_if.slave (cmd_* in, out_* / status out)
//   TRAIL_PEEK_EN defined adds top_valid_o/top_var_o/top_val_o/top_is_decision_o
module trail_stack #(
   parameter int DEPTH = 512,
   parameter int VAR_W = 9,
   parameter int LVL_W = 9
) (
   input  logic             clk_i,
   input  logic             reset_i,
   trail_stack_if.slave     bus
`ifdef TRAIL_PEEK_EN
   ,
   output logic             top_valid_o,
   output logic [VAR_W-1:0] top_var_o,
   output logic             top_val_o,
   output logic             top_is_decision_o
`endif
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = VAR_W + 2;
   typedef enum logic {IDLE, BACKTRACK} state_e;
   // entry layout: {is_decision, val, var}
   logic [EW-1:0]    mem_q [DEPTH];
   state_e           state_q, state_d;
   logic [CW-1:0]    count_q, count_d, top_idx;
   logic [LVL_W-1:0] level_q, level_d, target_q, target_d;
   logic             out_valid_q, out_valid_d;
   logic [EW-1:0]    out_q, out_d, top;
   logic             err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
   logic             acc, push, push_ok, pop_cmd, bt_start, bt_step, do_pop;
   assign bus.cmd_ready = (state_q == IDLE) & ~reset_i;
   assign acc      = bus.cmd_valid & bus.cmd_ready;
   assign top_idx  = count_q - CW'(1);
   assign top      = mem_q[top_idx[AW-1:0]];
   assign push     = acc & ~bus.cmd_op[1];
   assign push_ok  = push & (count_q != CW'(DEPTH)) & ~(bus.cmd_op[0] & (&level_q));
   assign pop_cmd  = acc & (bus.cmd_op == 2'b10);
   // the first backtrack pop happens in the accept cycle so out_valid lines up with busy
   assign bt_start = acc & (bus.cmd_op == 2'b11) & (bus.cmd_level < level_q);
   assign bt_step  = (state_q == BACKTRACK) & (level_q != target_q) & (count_q != '0);
   assign do_pop   = (pop_cmd & (count_q != '0)) | bt_start | bt_step;
   always_comb begin
      state_d     = bt_start ? BACKTRACK : (state_q == BACKTRACK && !bt_step) ? IDLE : state_q;
      target_d    = bt_start ? bus.cmd_level : target_q;
      count_d     = push_ok ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
      level_d     = push_ok ? level_q + LVL_W'(bus.cmd_op[0])
                  : do_pop ? level_q - LVL_W'(top[EW-1]) : level_q;
      out_valid_d = do_pop;
      out_d       = do_pop ? top : out_q;
      err_ovf_d   = err_ovf_q | (push & ~push_ok);
      err_unf_d   = err_unf_q | (pop_cmd & (count_q == '0));
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q     <= IDLE;
         target_q    <= '0;
         count_q     <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         count_q     <= count_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   always_ff @(posedge clk_i)
      if (push_ok) mem_q[count_q[AW-1:0]] <= {bus.cmd_op[0], bus.cmd_val, bus.cmd_var};
   assign bus.out_valid       = out_valid_q;
   assign bus.out_var         = out_q[VAR_W-1:0];
   assign bus.out_val         = out_q[VAR_W];
   assign bus.out_is_decision = out_q[EW-1];
   assign bus.busy            = state_q == BACKTRACK;
   assign bus.count           = count_q;
   assign bus.cur_level       = level_q;
   assign bus.empty           = count_q == '0;
   assign bus.full            = count_q == CW'(DEPTH);
   assign bus.err_overflow    = err_ovf_q;
   assign bus.err_underflow   = err_unf_q;
`ifdef TRAIL_PEEK_EN
   assign top_valid_o       = count_q != '0;
   assign top_var_o         = top[VAR_W-1:0];
   assign top_val_o         = top[VAR_W];
   assign top_is_decision_o = top[EW-1];
`endif
endmodule
